// File: rtl/subtractor32_sequential.sv
// Multi-cycle subtractor: diff = a - b, nb_digit bits per clock, LSB digit first, rippled borrow.
// Optional signed overflow flag is built only when SUB_SIGNED_OVF_EN is defined; otherwise ovf_o is tied to 0.
module subtractor32_sequential #(
  parameter int nb_bits  = 32,
  parameter int nb_digit = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [nb_bits-1:0] a_i,
  input  logic [nb_bits-1:0] b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [nb_bits:0]   diff_o,
  output logic               ovf_o
);

  localparam int N     = nb_bits / nb_digit;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((nb_digit < 1) || (nb_digit > nb_bits) || ((nb_bits % nb_digit) != 0)) begin : g_bad_param
    $error("subtractor32_sequential: nb_digit must divide nb_bits and lie in 1..nb_bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [nb_bits-1:0] a_r;
  logic [nb_bits-1:0] b_r;
  logic [nb_bits:0]   diff_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               borrow_r;
  logic               valid_r;
  logic               ready_r;

  logic [nb_digit-1:0] a_dig_s;
  logic [nb_digit-1:0] b_dig_s;
  logic [nb_digit:0]   sub_s;

  // Current digit difference; bit nb_digit of sub_s is the outgoing borrow.
  always_comb begin
    a_dig_s = a_r[cnt_r*nb_digit +: nb_digit];
    b_dig_s = b_r[cnt_r*nb_digit +: nb_digit];
    sub_s   = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {{nb_digit{1'b0}}, borrow_r};
  end

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_r;

  // Signed overflow: operand signs differ and the result sign departs from the minuend.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_r <= 1'b0;
    end else if ((state_r == IDLE) && valid_i) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && (cnt_r == LAST)) begin
      ovf_r <= (a_r[nb_bits-1] != b_r[nb_bits-1]) && (sub_s[nb_digit-1] != a_r[nb_bits-1]);
    end
  end

  assign ovf_o = ovf_r;
`else
  assign ovf_o = 1'b0;
`endif

  // Control FSM and datapath registers; ready/valid are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      cnt_r    <= '0;
      borrow_r <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            a_r      <= a_i;
            b_r      <= b_i;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            ready_r  <= 1'b0;
            state_r  <= RUN;
          end
        end
        RUN: begin
          diff_r[cnt_r*nb_digit +: nb_digit] <= sub_s[nb_digit-1:0];
          borrow_r <= sub_s[nb_digit];
          if (cnt_r == LAST) begin
            diff_r[nb_bits] <= sub_s[nb_digit];
            cnt_r           <= '0;
            valid_r         <= 1'b1;
            state_r         <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_r;
  assign valid_o = valid_r;
  assign diff_o  = diff_r;

endmodule
